// File: rtl/wrd_fc_pkg.sv
// -----------------------------------------------------------------------------
// wrd_fc_pkg
//   Shared definitions for the fully-connected parameter path of the wrd MAC:
//   streamer state encoding, default datapath widths, and the idle timeout
//   that must stay identical between the MAC and the parameter streamer.
// -----------------------------------------------------------------------------
package wrd_fc_pkg;

  localparam int FC_I_BW           = 8;
  localparam int FC_BIAS_BW        = FC_I_BW * 2;
  localparam int FC_NUM_CLASSES    = 3;
  localparam int FC_VEC_LEN        = 16;
  // Must match the MAC's accumulator idle-clear timeout.
  localparam int FC_TIMEOUT_CYCLES = 8;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } fc_state_t;

endpackage

// File: rtl/fc_param_ram.sv
// -----------------------------------------------------------------------------
// fc_param_ram
//   Single-port weight-vector memory. Synchronous write, synchronous read with
//   read-old-data behaviour when read and write hit the same cycle. The read
//   register is the streamer's data_w_o, so it is the only part that resets.
//
// Ports
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset (read register only)
//   we_i     in   write enable
//   re_i     in   read enable; read register holds when low
//   addr_i   in   shared read/write address
//   wdata_i  in   write data
//   rdata_o  out  registered read data
// -----------------------------------------------------------------------------
module fc_param_ram
  import wrd_fc_pkg::*;
#(
  parameter int DATA_BW = FC_NUM_CLASSES * FC_I_BW,
  parameter int DEPTH   = FC_VEC_LEN,
  parameter int ADDR_BW = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [ADDR_BW-1:0] addr_i,
  input  logic [DATA_BW-1:0] wdata_i,
  output logic [DATA_BW-1:0] rdata_o
);

  logic [DATA_BW-1:0] r_mem [DEPTH];
  logic [DATA_BW-1:0] r_rdata;

  // NOTE: the storage array has no reset on purpose: it maps onto RAM macros,
  // and contents must survive rst_i so streaming can resume without a reload.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[addr_i] <= wdata_i;
    end
  end

  // NOTE: non-blocking assignment here is what gives read-old-data: the read
  // samples r_mem before the same-edge write lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (re_i) begin
      r_rdata <= r_mem[addr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/fc_param_streamer.sv
// -----------------------------------------------------------------------------
// fc_param_streamer
//   Transmit side of the fully-connected parameter stream for the wrd MAC.
//   Stores VEC_LEN weight vectors plus one bias vector, then presents one
//   weight vector per accepted activation beat (valid_o && ready_i &&
//   act_valid_i) in the same cycle as that beat. The next vector is prefetched
//   from the RAM so there is no bubble between beats. An idle counter mirrors
//   the MAC's accumulator-clear timeout and rewinds the packet index to 0.
//
// Optional feature
//   FC_PARAM_FRAME_CNT_EN : when defined, frame_cnt_o counts beats that carry
//                           last_o (wraps at 2^16). Otherwise tied to 0.
//
// Ports
//   clk_i         in   clock
//   rst_i         in   synchronous active-high reset
//   wr_en_i       in   weight-vector write strobe (LOAD only)
//   wr_addr_i     in   weight-vector write index
//   wr_data_i     in   packed weights, class i at [(i+1)*I_BW-1 : i*I_BW]
//   bias_wr_en_i  in   bias write strobe (LOAD only)
//   bias_data_i   in   packed biases, same packing
//   start_i       in   begin streaming
//   stop_i        in   return to LOAD at the next packet boundary
//   act_valid_i   in   activation-stream valid
//   data_w_o      out  current weight vector (registered)
//   data_b_o      out  bias vector (registered)
//   valid_o       out  parameter valid
//   last_o        out  final element of packet
//   ready_i       in   downstream ready
//   timeout_o     out  one-cycle pulse on idle rewind
//   frame_cnt_o   out  packets sent
// -----------------------------------------------------------------------------
module fc_param_streamer
  import wrd_fc_pkg::*;
#(
  parameter int I_BW           = FC_I_BW,
  parameter int BIAS_BW        = I_BW * 2,
  parameter int NUM_CLASSES    = FC_NUM_CLASSES,
  parameter int VEC_LEN        = FC_VEC_LEN,   // must be >= 4
  parameter int ADDR_BW        = $clog2(VEC_LEN),
  parameter int TIMEOUT_CYCLES = FC_TIMEOUT_CYCLES
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           wr_en_i,
  input  logic [ADDR_BW-1:0]             wr_addr_i,
  input  logic [NUM_CLASSES*I_BW-1:0]    wr_data_i,
  input  logic                           bias_wr_en_i,
  input  logic [NUM_CLASSES*BIAS_BW-1:0] bias_data_i,
  input  logic                           start_i,
  input  logic                           stop_i,
  input  logic                           act_valid_i,
  output logic [NUM_CLASSES*I_BW-1:0]    data_w_o,
  output logic [NUM_CLASSES*BIAS_BW-1:0] data_b_o,
  output logic                           valid_o,
  output logic                           last_o,
  input  logic                           ready_i,
  output logic                           timeout_o,
  output logic [15:0]                    frame_cnt_o
);

  localparam int                 IDLE_BW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_BW-1:0] LAST_IDX = ADDR_BW'(VEC_LEN - 1);
  localparam logic [IDLE_BW-1:0] IDLE_MAX = IDLE_BW'(TIMEOUT_CYCLES);
  localparam logic [IDLE_BW-1:0] IDLE_HIT = IDLE_BW'(TIMEOUT_CYCLES - 1);

  fc_state_t                      r_state;
  fc_state_t                      w_state_next;
  logic [ADDR_BW-1:0]             r_idx;
  logic [ADDR_BW-1:0]             w_idx_next;
  logic [ADDR_BW-1:0]             w_idx_inc;
  logic [IDLE_BW-1:0]             r_idle;
  logic                           r_pending;
  logic                           w_pending_next;
  logic                           r_valid;
  logic                           r_last;
  logic                           r_timeout;
  logic                           w_timeout_next;
  logic [NUM_CLASSES*BIAS_BW-1:0] r_bias;
  logic                           w_beat;
  logic                           w_rewind;
  logic                           w_ram_we;
  logic                           w_ram_re;
  logic [ADDR_BW-1:0]             w_ram_addr;

  assign w_beat    = r_valid && ready_i && act_valid_i;
  assign w_idx_inc = (r_idx == LAST_IDX) ? '0 : r_idx + ADDR_BW'(1);

  // The counter reaches TIMEOUT_CYCLES on this edge: same cycle the MAC clears
  // its accumulator. At idx 0 there is nothing to realign, so no pulse.
  assign w_rewind = (r_state == ST_STREAM) && !act_valid_i &&
                    (r_idle == IDLE_HIT) && (r_idx != '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, index, RAM port control
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is defaulted first so no path through
  // the case leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_pending_next = r_pending;
    w_timeout_next = 1'b0;
    w_ram_we       = 1'b0;
    w_ram_re       = 1'b0;
    w_ram_addr     = r_idx;

    case (r_state)
      ST_LOAD: begin
        w_ram_addr     = wr_addr_i;
        w_ram_we       = wr_en_i;
        w_idx_next     = '0;
        w_pending_next = 1'b0;
        // The single RAM port is busy with the write, so start must wait.
        if (start_i && !wr_en_i) begin
          w_state_next = ST_PRIME;
        end
      end

      ST_PRIME: begin
        w_ram_re     = 1'b1;
        w_ram_addr   = '0;
        w_idx_next   = '0;
        w_state_next = ST_STREAM;
      end

      ST_STREAM: begin
        // Reading continuously keeps data_w_o equal to mem[idx] during stalls.
        w_ram_re = 1'b1;
        if (w_rewind) begin
          w_idx_next     = '0;
          w_ram_addr     = '0;
          w_timeout_next = 1'b1;
          if (r_pending || stop_i) begin
            w_state_next   = ST_LOAD;
            w_pending_next = 1'b0;
          end
        end else if (stop_i && (r_idx == '0)) begin
          w_state_next   = ST_LOAD;
          w_idx_next     = '0;
          w_pending_next = 1'b0;
        end else begin
          if (stop_i) begin
            w_pending_next = 1'b1;
          end
          if (w_beat) begin
            w_idx_next = w_idx_inc;
            w_ram_addr = w_idx_inc;
            if (r_last && (r_pending || stop_i)) begin
              w_state_next   = ST_LOAD;
              w_pending_next = 1'b0;
            end
          end
        end
      end

      default: begin
        w_state_next = ST_LOAD;
        w_idx_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Index, stop latch, idle counter and registered flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_idle    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_idx     <= w_idx_next;
      r_pending <= w_pending_next;
      if (act_valid_i) begin
        r_idle <= '0;
      end else if (r_idle != IDLE_MAX) begin
        r_idle <= r_idle + IDLE_BW'(1);
      end
      // Flags are computed from the next state/index so they change on the
      // same edge as the prefetched data_w_o.
      r_valid   <= (w_state_next == ST_STREAM);
      r_last    <= (w_state_next == ST_STREAM) && (w_idx_next == LAST_IDX);
      r_timeout <= w_timeout_next;
    end
  end

  // Bias register: only writable while loading.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bias <= '0;
    end else if ((r_state == ST_LOAD) && bias_wr_en_i) begin
      r_bias <= bias_data_i;
    end
  end

  fc_param_ram #(
    .DATA_BW (NUM_CLASSES * I_BW),
    .DEPTH   (VEC_LEN),
    .ADDR_BW (ADDR_BW)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (w_ram_we),
    .re_i    (w_ram_re),
    .addr_i  (w_ram_addr),
    .wdata_i (wr_data_i),
    .rdata_o (data_w_o)
  );

`ifdef FC_PARAM_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_frame_cnt <= '0;
    end else if (w_beat && r_last) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt_o = r_frame_cnt;
`else
  assign frame_cnt_o = '0;
`endif

  assign data_b_o  = r_bias;
  assign valid_o   = r_valid;
  assign last_o    = r_last;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_fc_param_streamer.sv
// -----------------------------------------------------------------------------
// tb_fc_param_streamer
//   Scoreboard bench for fc_param_streamer with VEC_LEN=4, TIMEOUT_CYCLES=8.
//   Expected beats are queued when stimulus is prepared and compared whenever
//   a beat is accepted. Inputs change #1 after posedge; outputs are read then.
// -----------------------------------------------------------------------------
module tb_fc_param_streamer;

  localparam int I_BW  = 8;
  localparam int B_BW  = 16;
  localparam int NC    = 3;
  localparam int VL    = 4;
  localparam int AB    = 2;
  localparam int TO    = 8;
  localparam int WW    = NC * I_BW;
  localparam int BW    = NC * B_BW;

  typedef struct packed {
    logic [WW-1:0] w;
    logic [BW-1:0] b;
    logic          last;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          wr_en_i = 1'b0;
  logic [AB-1:0] wr_addr_i = '0;
  logic [WW-1:0] wr_data_i = '0;
  logic          bias_wr_en_i = 1'b0;
  logic [BW-1:0] bias_data_i = '0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          act_valid_i = 1'b0;
  logic          ready_i = 1'b1;
  logic [WW-1:0] data_w_o;
  logic [BW-1:0] data_b_o;
  logic          valid_o;
  logic          last_o;
  logic          timeout_o;
  logic [15:0]   frame_cnt_o;

  int            n_checks = 0;
  int            n_fail = 0;
  int            exp_frames = 0;
  logic [WW-1:0] tb_mem [VL];
  logic [BW-1:0] tb_bias = '0;
  beat_t         sb [$];

  always #5 clk_i = ~clk_i;

  fc_param_streamer #(
    .I_BW           (I_BW),
    .BIAS_BW        (B_BW),
    .NUM_CLASSES    (NC),
    .VEC_LEN        (VL),
    .ADDR_BW        (AB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .bias_wr_en_i (bias_wr_en_i),
    .bias_data_i  (bias_data_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .act_valid_i  (act_valid_i),
    .data_w_o     (data_w_o),
    .data_b_o     (data_b_o),
    .valid_o      (valid_o),
    .last_o       (last_o),
    .ready_i      (ready_i),
    .timeout_o    (timeout_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  // Scoreboard pop/compare for one accepted beat.
  task automatic sb_compare();
    beat_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL beat_unexpected: got w=%h last=%b, required no beat", data_w_o, last_o);
    end else begin
      e = sb.pop_front();
      if (e.last) exp_frames++;
      if (data_w_o !== e.w) begin
        n_fail++;
        $display("FAIL beat_w: got %h, required %h", data_w_o, e.w);
      end
      n_checks++;
      if (last_o !== e.last) begin
        n_fail++;
        $display("FAIL beat_last: got %b, required %b (w=%h)", last_o, e.last, e.w);
      end
      n_checks++;
      if (data_b_o !== e.b) begin
        n_fail++;
        $display("FAIL beat_b: got %h, required %h", data_b_o, e.b);
      end
    end
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic step();
    if (valid_o && ready_i && act_valid_i) sb_compare();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_beat(input int k);
    beat_t e;
    e.w    = tb_mem[k];
    e.b    = tb_bias;
    e.last = (k == VL - 1);
    sb.push_back(e);
  endtask

  task automatic push_packet();
    for (int k = 0; k < VL; k++) push_beat(k);
  endtask

  // Run beats until the scoreboard is empty, with a cycle budget.
  task automatic drain(input string tag);
    int budget;
    budget = 64;
    act_valid_i = 1'b1;
    while (sb.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    act_valid_i = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic start_stream(input string tag);
    act_valid_i = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    n_checks++;
    if (valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_start_valid: got %b, required 1", tag, valid_o);
    end
  endtask

  task automatic write_mem(input int k, input logic [WW-1:0] d, input logic with_start);
    tb_mem[k] = d;
    wr_en_i   = 1'b1;
    wr_addr_i = AB'(k);
    wr_data_i = d;
    start_i   = with_start;
    step();
    wr_en_i   = 1'b0;
    start_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    n_checks += 6;
    if (valid_o !== 1'b0)     begin n_fail++; $display("FAIL rst_valid: got %b, required 0", valid_o); end
    if (last_o !== 1'b0)      begin n_fail++; $display("FAIL rst_last: got %b, required 0", last_o); end
    if (timeout_o !== 1'b0)   begin n_fail++; $display("FAIL rst_timeout: got %b, required 0", timeout_o); end
    if (data_w_o !== '0)      begin n_fail++; $display("FAIL rst_data_w: got %h, required 0", data_w_o); end
    if (data_b_o !== '0)      begin n_fail++; $display("FAIL rst_data_b: got %h, required 0", data_b_o); end
    if (frame_cnt_o !== '0)   begin n_fail++; $display("FAIL rst_frame_cnt: got %0d, required 0", frame_cnt_o); end
  endtask

  task automatic test_load_stream();
    for (int k = 0; k < VL; k++) begin
      // The last write also asserts start, which must be ignored.
      write_mem(k, {8'(k + 3), 8'(k + 2), 8'(k + 1)}, (k == VL - 1));
    end
    step();
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL start_with_write: valid got %b, required 0", valid_o);
    end
    tb_bias      = {16'd30, 16'd20, 16'd10};
    bias_wr_en_i = 1'b1;
    bias_data_i  = tb_bias;
    step();
    bias_wr_en_i = 1'b0;
    n_checks++;
    if (data_b_o !== tb_bias) begin
      n_fail++;
      $display("FAIL bias_load: got %h, required %h", data_b_o, tb_bias);
    end
    start_stream("load");
    n_checks++;
    if (data_w_o !== tb_mem[0]) begin
      n_fail++;
      $display("FAIL prime_data: got %h, required %h", data_w_o, tb_mem[0]);
    end
    push_packet();
    push_packet();
    drain("load");
  endtask

  task automatic test_stall();
    push_beat(0);
    push_beat(1);
    drain("stall_pre");
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks += 2;
      if (data_w_o !== tb_mem[2]) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got %h, required %h", c, data_w_o, tb_mem[2]);
      end
      if (timeout_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_timeout_%0d: got %b, required 0", c, timeout_o);
      end
    end
    push_beat(2);
    push_beat(3);
    drain("stall_post");
  endtask

  task automatic test_timeout();
    int pulses;
    push_beat(0);
    push_beat(1);
    drain("to_pre");
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (timeout_o === 1'b1) pulses++;
    end
    n_checks += 4;
    if (pulses != 1)            begin n_fail++; $display("FAIL timeout_pulses: got %0d, required 1", pulses); end
    if (data_w_o !== tb_mem[0]) begin n_fail++; $display("FAIL timeout_data: got %h, required %h", data_w_o, tb_mem[0]); end
    if (last_o !== 1'b0)        begin n_fail++; $display("FAIL timeout_last: got %b, required 0", last_o); end
    if (valid_o !== 1'b1)       begin n_fail++; $display("FAIL timeout_valid: got %b, required 1", valid_o); end
    push_packet();
    drain("to_post");
  endtask

  task automatic test_stop();
    push_beat(0);
    drain("stop_pre");
    push_beat(1);
    push_beat(2);
    push_beat(3);
    act_valid_i = 1'b1;
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    drain("stop");
    n_checks += 2;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stop_valid: got %b, required 0", valid_o); end
    if (last_o !== 1'b0)  begin n_fail++; $display("FAIL stop_last: got %b, required 0", last_o); end
    act_valid_i = 1'b1;
    repeat (3) step();   // any beat here is flagged as unexpected
    act_valid_i = 1'b0;
    write_mem(0, {8'd9, 8'd8, 8'd7}, 1'b0);
    start_stream("stop_restart");
    push_packet();
    drain("stop_restart");
    // stop at idx 0 leaves immediately
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stop_idx0_valid: got %b, required 0", valid_o); end
  endtask

  task automatic test_stop_rewind();
    start_stream("srw");
    push_beat(0);
    push_beat(1);
    drain("srw_pre");
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    repeat (TO - 1) step();
    n_checks += 3;
    if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL srw_timeout: got %b, required 1", timeout_o); end
    if (valid_o !== 1'b0)   begin n_fail++; $display("FAIL srw_valid: got %b, required 0", valid_o); end
    step();
    if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL srw_pulse_width: got %b, required 0", timeout_o); end
  endtask

  task automatic test_lockout_reset();
    start_stream("lock");
    push_beat(0);
    drain("lock_pre");
    wr_en_i      = 1'b1;
    wr_addr_i    = AB'(2);
    wr_data_i    = 24'hAAAAAA;
    bias_wr_en_i = 1'b1;
    bias_data_i  = '1;
    step();
    wr_en_i      = 1'b0;
    bias_wr_en_i = 1'b0;
    push_beat(1);
    push_beat(2);
    drain("lock");
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    tb_bias    = '0;
    exp_frames = 0;
    n_checks += 5;
    if (valid_o !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_valid: got %b, required 0", valid_o); end
    if (last_o !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_last: got %b, required 0", last_o); end
    if (data_w_o !== '0)    begin n_fail++; $display("FAIL mid_rst_data_w: got %h, required 0", data_w_o); end
    if (data_b_o !== '0)    begin n_fail++; $display("FAIL mid_rst_data_b: got %h, required 0", data_b_o); end
    if (frame_cnt_o !== '0) begin n_fail++; $display("FAIL mid_rst_frame: got %0d, required 0", frame_cnt_o); end
    start_stream("post_rst");
    push_packet();
    drain("post_rst");
  endtask

  task automatic test_frame_cnt();
    logic [15:0] exp;
    push_packet();
    push_packet();
    push_packet();
    drain("frames");
`ifdef FC_PARAM_FRAME_CNT_EN
    exp = 16'(exp_frames);
`else
    exp = 16'd0;
`endif
    n_checks++;
    if (frame_cnt_o !== exp) begin
      n_fail++;
      $display("FAIL frame_cnt: got %0d, required %0d", frame_cnt_o, exp);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_load_stream();
    test_stall();
    test_timeout();
    test_stop();
    test_stop_rewind();
    test_lockout_reset();
    test_frame_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/fc_param_streamer.md
Name: fc_param_streamer

Overview:
- Transmit side of the fully-connected parameter stream for the wrd MAC.
- Holds VEC_LEN weight vectors (NUM_CLASSES weights each) and one bias vector, all loaded through a write port.
- Presents one weight vector per accepted activation beat, in the same cycle as that beat, with bias held constant and last on the final element.
- Re-aligns with the MAC's idle-timeout accumulator clear.

Parameters:
- I_BW, 8: weight bitwidth
- BIAS_BW, I_BW*2: bias bitwidth
- NUM_CLASSES, 3: output classes (weights per vector)
- VEC_LEN, 16: activation beats per packet; must be >= 4
- ADDR_BW, $clog2(VEC_LEN): index/write-address width
- TIMEOUT_CYCLES, 8: idle cycles before rewind; must equal the MAC's timeout

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset; synchronous, active-high
- wr_en_i  in  1  weight-vector write strobe
- wr_addr_i  in  ADDR_BW  weight-vector write index
- wr_data_i  in  NUM_CLASSES*I_BW  packed weights; class i in bits [(i+1)*I_BW-1 : i*I_BW]
- bias_wr_en_i  in  1  bias write strobe
- bias_data_i  in  NUM_CLASSES*BIAS_BW  packed biases, same packing
- start_i  in  1  begin streaming
- stop_i  in  1  return to load at next packet boundary
- act_valid_i  in  1  activation-stream valid, same cycle as the MAC's data0 valid
- data_w_o  out  NUM_CLASSES*I_BW  current weight vector (registered)
- data_b_o  out  NUM_CLASSES*BIAS_BW  bias vector (registered)
- valid_o  out  1  parameter valid
- last_o  out  1  final element of packet
- ready_i  in  1  downstream ready
- timeout_o  out  1  one-cycle pulse on rewind
- frame_cnt_o  out  16  packets sent; see Optional Feature

Behaviour:
- Reset values:
  - state LOAD; idx 0; idle counter 0
  - valid_o, last_o, timeout_o, data_w_o, data_b_o, frame_cnt_o all 0
  - memory contents are not reset.
- Beat: valid_o && ready_i && act_valid_i.
- States:
  - LOAD:
    - valid_o = 0.
    - wr_en_i writes mem[wr_addr_i]; bias_wr_en_i writes the bias register, which drives data_b_o one cycle later.
    - start_i with wr_en_i low -> PRIME. start_i with wr_en_i high -> write performed, start ignored.
  - PRIME:
    - one cycle; synchronous read of mem[0] into data_w_o; -> STREAM.
    - valid_o = 1 from the first STREAM cycle.
  - STREAM:
    - valid_o = 1.
    - On a beat: idx <= (idx == VEC_LEN-1) ? 0 : idx+1, and data_w_o <= mem[next idx]. The read address is combinationally next-idx on a beat, idx otherwise, so the data is prefetched with zero bubble.
    - last_o = valid_o && (idx == VEC_LEN-1), registered alongside data_w_o.
    - Writes (wr_en_i, bias_wr_en_i) are ignored.
- stop_i in STREAM:
  - idx == 0 -> LOAD next cycle.
  - Otherwise latch a pending stop; on the beat carrying last_o -> LOAD.
- Idle counter:
  - Clears on act_valid_i.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES in STREAM with idx != 0: idx <= 0, data_w_o <= mem[0], last_o <= 0, timeout_o pulses one cycle. This matches the MAC's accumulator clear.
  - With idx == 0, no pulse.
- Stalls: ready_i low or act_valid_i low -> outputs held, idx held.
- Simultaneous rewind and stop pending: rewind, then -> LOAD (idx 0).
- rst_i mid-packet: everything returns to reset values next cycle; the memory keeps its contents, so start_i resumes at idx 0 without reload.

Optional Feature:
- Macro FC_PARAM_FRAME_CNT_EN.
  - Defined: frame_cnt_o increments (wrapping at 2^16) on every beat with last_o = 1, clears on reset only.
  - Undefined: counter logic omitted; frame_cnt_o tied to 0.

Decomposition:
- Shared include/package wrd_fc_pkg:
  - state encodings LOAD=2'd0, PRIME=2'd1, STREAM=2'd2
  - FC_TIMEOUT_CYCLES=8, shared with mac
  - default I_BW, BIAS_BW, NUM_CLASSES
- One sub-module fc_param_ram: single-port memory, sync write, sync read with read-old-data semantics, width NUM_CLASSES*I_BW, depth VEC_LEN.

Test Plan (VEC_LEN=4):
- Load + stream:
  - Stimulus: write mem[k] = {k+3, k+2, k+1} for k=0..3; bias {16'd30, 16'd20, 16'd10}; start; act_valid_i=1, ready_i=1.
  - Response: data_w_o classes 0..2 = (1,2,3), (2,3,4), (3,4,5), (4,5,6) on consecutive cycles; last_o only on the 4th; then wraps to (1,2,3); data_b_o constant.
- Stall:
  - Stimulus: act_valid_i low at idx 2 for 3 cycles, then high.
  - Response: data_w_o held at mem[2]; no skip or repeat after resume.
- Timeout:
  - Stimulus: stop act_valid_i at idx 2 for 8 cycles.
  - Response: timeout_o pulses once; next beat carries mem[0] with last_o=0.
- Stop:
  - Stimulus: stop_i at idx 1.
  - Response: beats 1..3 complete; valid_o drops the cycle after the last_o beat; later writes to mem[0] take effect on the next start.
- Write lockout + reset:
  - Stimulus: wr_en_i during STREAM, then rst_i mid-packet, then start.
  - Response: memory unchanged; all outputs 0 after reset; stream restarts at mem[0].
- Frame counter (macro defined):
  - Stimulus: stream 3 packets.
  - Response: frame_cnt_o = 3.
